// File: rtl/sw_debounce.sv
// Purpose: synchronize and debounce slide switches, flag debounced changes, optional sticky edge capture + irq.
// Latency: sw_out follows a held sw_in level STABLE_CYCLES+1 edges after the first sampling edge.
// Backpressure: none; irq_ack is a single-cycle clear pulse, a coincident toggle wins over the clear.
//
// Ports:
//   clk_clk        only clock (CLOCK_50)
//   reset_reset_n  synchronous active-low reset
//   sw_in          raw asynchronous switch levels
//   sw_out         debounced levels to the switches PIO
//   change_pulse   one-cycle strobe when any sw_out bit changes (after startup priming)
//   edge_cap       sticky per-bit change record since last ack
//   irq            |edge_cap
//   irq_ack        clears edge_cap
// Build option: define SW_DEBOUNCE_IRQ_EN to implement edge_cap/irq/irq_ack;
// otherwise edge_cap and irq are tied low and irq_ack is ignored.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 19
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             change_pulse,
    output logic [WIDTH-1:0] edge_cap,
    output logic             irq,
    input  logic             irq_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_MAX = CNT_W'(STABLE_CYCLES + 2);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] sw_out_q, sw_out_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
    logic             primed_q, primed_d;
    logic             change_pulse_q, change_pulse_d;
    logic [WIDTH-1:0] toggle;

    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        toggle   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                toggle[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        sw_out_d = sw_out_q ^ toggle;

        // Startup window covers the synchronizer plus one full debounce period,
        // so switches already high at power-up settle without raising an event.
        start_cnt_d    = (start_cnt_q == START_MAX) ? start_cnt_q : start_cnt_q + 1'b1;
        primed_d       = primed_q | (start_cnt_q == START_MAX);
        change_pulse_d = primed_q & (|toggle);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            sw_out_q       <= '0;
            start_cnt_q    <= '0;
            primed_q       <= 1'b0;
            change_pulse_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sw_out_q       <= sw_out_d;
            start_cnt_q    <= start_cnt_d;
            primed_q       <= primed_d;
            change_pulse_q <= change_pulse_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_out       = sw_out_q;
    assign change_pulse = change_pulse_q;

`ifdef SW_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;

    // New toggles are OR'd in after the ack clear so a coincident toggle is never lost.
    always_comb begin
        edge_cap_d = (irq_ack ? '0 : edge_cap_q) | (primed_q ? toggle : '0);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            edge_cap_q <= '0;
        end else begin
            edge_cap_q <= edge_cap_d;
        end
    end

    assign edge_cap = edge_cap_q;
    assign irq      = |edge_cap_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign edge_cap       = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Purpose: directed check of sw_debounce with STABLE_CYCLES=16 (startup, toggle, ack race, bounce, reset).
// Latency: expectations use sw_out change at edge k+17 for first sampling edge k.
// Backpressure: n/a; edge_cap/irq expectations collapse to 0 when SW_DEBOUNCE_IRQ_EN is not defined.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_in;
    logic [7:0] sw_out;
    logic       change_pulse;
    logic [7:0] edge_cap;
    logic       irq;
    logic       irq_ack;

    int total = 0;
    int bad   = 0;

    sw_debounce #(.WIDTH(8), .STABLE_CYCLES(16), .CNT_W(5)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw_in         (sw_in),
        .sw_out        (sw_out),
        .change_pulse  (change_pulse),
        .edge_cap      (edge_cap),
        .irq           (irq),
        .irq_ack       (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] sw;
        logic       ack;
        int         n;
        logic [7:0] e_out;
        logic       e_pulse;
        logic [7:0] e_cap;
    } vec_t;

    vec_t tv [12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] e_out, input logic e_pulse,
                           input logic [7:0] e_cap);
        logic [7:0] cap;
        cap = IRQ_EN ? e_cap : 8'h00;
        chk({nm, ".sw_out"}, {24'h0, sw_out}, {24'h0, e_out});
        chk({nm, ".pulse"}, {31'h0, change_pulse}, {31'h0, e_pulse});
        chk({nm, ".edge_cap"}, {24'h0, edge_cap}, {24'h0, cap});
        chk({nm, ".irq"}, {31'h0, irq}, {31'h0, |cap});
    endtask

    initial begin
        // Edges are numbered from reset release; toggles land at k+17.
        tv[0]  = '{1'b0, 8'hA5, 1'b0,  3, 8'h00, 1'b0, 8'h00}; // reset state
        tv[1]  = '{1'b1, 8'hA5, 1'b0, 17, 8'h00, 1'b0, 8'h00}; // edge 17
        tv[2]  = '{1'b1, 8'hA5, 1'b0,  1, 8'hA5, 1'b0, 8'h00}; // edge 18, unprimed
        tv[3]  = '{1'b1, 8'hA5, 1'b0,  1, 8'hA5, 1'b0, 8'h00}; // edge 19, primed
        tv[4]  = '{1'b1, 8'hA4, 1'b0, 17, 8'hA5, 1'b0, 8'h00}; // k=20, edge 36
        tv[5]  = '{1'b1, 8'hA4, 1'b0,  1, 8'hA4, 1'b1, 8'h01}; // edge 37
        tv[6]  = '{1'b1, 8'hA4, 1'b0,  1, 8'hA4, 1'b0, 8'h01}; // edge 38
        tv[7]  = '{1'b1, 8'h24, 1'b0, 17, 8'hA4, 1'b0, 8'h01}; // k=39, edge 55
        tv[8]  = '{1'b1, 8'h24, 1'b1,  1, 8'h24, 1'b1, 8'h80}; // edge 56: ack + bit7 toggle
        tv[9]  = '{1'b1, 8'h24, 1'b0,  1, 8'h24, 1'b0, 8'h80};
        tv[10] = '{1'b1, 8'h24, 1'b1,  1, 8'h24, 1'b0, 8'h00}; // plain ack
        tv[11] = '{1'b1, 8'h24, 1'b0,  1, 8'h24, 1'b0, 8'h00};

        rst_n   = 1'b0;
        sw_in   = 8'h00;
        irq_ack = 1'b0;
        tick(1);

        for (int v = 0; v < 12; v++) begin
            rst_n   = tv[v].rst_n;
            sw_in   = tv[v].sw;
            irq_ack = tv[v].ack;
            tick(tv[v].n);
            chk_all($sformatf("vec%0d", v), tv[v].e_out, tv[v].e_pulse, tv[v].e_cap);
        end
        irq_ack = 1'b0;

        // Bounce on bit 3 every 5 cycles for 60 cycles, then hold high.
        for (int seg = 0; seg < 12; seg++) begin
            sw_in = (seg % 2 == 0) ? 8'h2C : 8'h24;
            for (int c = 0; c < 5; c++) begin
                tick(1);
                chk_all("bounce", 8'h24, 1'b0, 8'h00);
            end
        end
        sw_in = 8'h2C;
        for (int c = 0; c < 17; c++) begin
            tick(1);
            chk_all("bounce_hold", 8'h24, 1'b0, 8'h00);
        end
        tick(1);
        chk_all("bounce_rise", 8'h2C, 1'b1, 8'h08);
        tick(1);
        chk_all("bounce_after", 8'h2C, 1'b0, 8'h08);

        // Reset in the middle of a bit-0 debounce.
        sw_in = 8'h2D;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk_all("pre_reset", 8'h2C, 1'b0, 8'h08);
        end
        rst_n = 1'b0;
        tick(1);
        chk_all("mid_reset", 8'h00, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick(1);
            chk_all($sformatf("restart_e%0d", e), 8'h00, 1'b0, 8'h00);
        end
        tick(1);
        chk_all("restart_e18", 8'h2D, 1'b0, 8'h00);
        tick(1);
        chk_all("restart_e19", 8'h2D, 1'b0, 8'h00);

        // Events resume once primed.
        sw_in = 8'h2F;
        tick(17);
        chk_all("resume_wait", 8'h2D, 1'b0, 8'h00);
        tick(1);
        chk_all("resume_rise", 8'h2F, 1'b1, 8'h02);
        tick(1);
        chk_all("resume_after", 8'h2F, 1'b0, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioner between the board slide switches and the Nios II switches PIO (`switches_export`). It synchronizes each raw switch bit into the `CLOCK_50` domain and debounces it with a per-bit stability counter. It drives the debounced vector to the PIO and reports every debounced change as a one-cycle strobe. Optionally it latches changed bits into a sticky edge-capture register with an interrupt and acknowledge handshake.

## Interface
- `WIDTH`, default 8: number of switch bits, matching `SW[7:0]`.
- `STABLE_CYCLES`, default 500000: consecutive cycles an input must differ before `sw_out` follows. This is 10 ms at 50 MHz. Minimum 2.
- `CNT_W`, default 19: counter width. Must satisfy 2^CNT_W > STABLE_CYCLES + 3.

- `clk_clk`, input, 1: `CLOCK_50`. This is the only clock.
- `reset_reset_n`, input, 1: synchronous, active-low reset (`KEY[0]`).
- `sw_in`, input, WIDTH: raw asynchronous switch levels.
- `sw_out`, output, WIDTH: debounced levels, wired to `switches_export`.
- `change_pulse`, output, 1: high for one cycle when any `sw_out` bit changes.
- `edge_cap`, output, WIDTH: sticky per-bit record of changes since the last acknowledge.
- `irq`, output, 1: equals |edge_cap.
- `irq_ack`, input, 1: single-cycle pulse that clears `edge_cap`.

## Operation
- Reset (`reset_reset_n`=0 at an edge) clears all of the following to 0:
  - sync stages, `sw_out`, counters, `change_pulse`, `edge_cap`, `irq`;
  - the startup counter and the `primed` flag.
- Synchronizer: two flops per bit, `sync1` then `sync2`. Downstream logic sees only `sync2`.
- Per-bit debounce counter `cnt[i]`, behaviour at each edge:
  - If `sync2[i]` equals `sw_out[i]`: `cnt[i]` is set to 0.
  - Else if `cnt[i]` equals STABLE_CYCLES-1: `sw_out[i]` toggles and `cnt[i]` is set to 0.
  - Else: `cnt[i]` increments.
- Any glitch shorter than STABLE_CYCLES cycles after synchronization restarts the count. The output never chatters.
- Bits are independent. Several bits may toggle on the same edge.
- Startup counter:
  - Counts from reset release up to STABLE_CYCLES+2, then saturates and sets `primed`=1.
  - While `primed`=0, toggles update `sw_out` but generate no `change_pulse` and no `edge_cap` bits.
  - This suppresses the spurious event caused by switches that are already high at power-up.
- `change_pulse`: registered. It is asserted in the same cycle `sw_out` first shows the new value, provided `primed`=1. Several simultaneous toggles produce one pulse.
- Arithmetic: counters are unsigned CNT_W bits and never wrap. They are cleared at STABLE_CYCLES-1 or on a match.

## Timing
- Latency: take edge k as the first edge that samples a new, held `sw_in` level. `sw_out` changes at edge k+STABLE_CYCLES+1.
- From reset release with constant `sw_in`, `sw_out` settles at edge STABLE_CYCLES+2. `primed` rises at edge STABLE_CYCLES+3.
- `edge_cap[i]` sets in the same cycle as `change_pulse`. `irq` is combinational from `edge_cap`.
- `irq_ack` high at an edge clears `edge_cap`, visible the next cycle.
- Ack coinciding with a toggle: the toggling bits remain set (set wins), and the other bits clear.
- Reset asserted mid-debounce: counts are discarded and all outputs return to 0 at that edge.

## Configuration
- `SW_DEBOUNCE_IRQ_EN` defined: the edge-capture register, `irq` and `irq_ack` handshake are implemented as described above.
- `SW_DEBOUNCE_IRQ_EN` undefined:
  - `edge_cap` is tied to 0, `irq` is tied to 0, and `irq_ack` is ignored.
  - `sw_out`, `change_pulse` and startup suppression are unchanged.

## Test plan
All scenarios use STABLE_CYCLES=16 and `SW_DEBOUNCE_IRQ_EN` defined.
- Startup: `sw_in`=0xA5 held through reset, then released.
  - `sw_out`=0x00 through edge 17, then 0xA5 at edge 18.
  - `change_pulse`=0, `edge_cap`=0x00, `irq`=0.
- Clean toggle: after `primed`, `sw_in` changes 0xA5→0xA4 at sampling edge k.
  - `sw_out`=0xA4 at edge k+17.
  - `change_pulse` is high for exactly that cycle, `edge_cap`=0x01, `irq`=1.
- Bounce: bit 3 toggles every 5 cycles for 60 cycles, then holds 1.
  - `sw_out[3]` stays 0 through the bounce.
  - It rises exactly 17 edges after the last transition, giving one `change_pulse`.
- Ack race: `edge_cap`=0x01 and `irq_ack` is pulsed on the same edge that bit 7 toggles.
  - The next cycle shows `edge_cap`=0x80 and `irq`=1.
- Reset mid-count: bit 0 differs for 10 cycles, then reset is pulsed for 1 cycle.
  - All outputs are 0 after the pulse, and the count restarts from 0.
  - `change_pulse` is suppressed until `primed`.
- Macro undefined: repeat the clean-toggle scenario.
  - `change_pulse` behaves identically.
  - `edge_cap`=0x00 and `irq`=0 throughout.
